fifo_write_ctrl: RTL and testbench
==================================

Name: fifo_write_ctrl

Overview:
- Parametrised successor of the single-channel FIFO write-enable FSM.
- Owns its own write counter: loads a burst length, then steers a write enable to one of CHANNELS FIFOs.
- Honours per-channel full flags, supports abort, and supports one-shot (sticky end) or continuous (auto-rearm) operation.
- Sits between the encoder control path and the bank of output FIFOs.

Parameters:
- COUNT_W, 16, width of burst length and write counter.
- CHANNELS, 4, number of FIFO channels driven (>=1); CH_W = max(1, clog2(CHANNELS)).
- STALL_TIMEOUT, 1024, consecutive full-stall cycles before timeout abort (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  launch request; sampled only in IDLE.
- length  in  COUNT_W  burst length in writes; latched on accepted start.
- chan_sel  in  CH_W  target channel; latched on accepted start.
- continuous  in  1  1 = auto-rearm after DONE; 0 = DONE sticky until clear; sampled in DONE.
- clear  in  1  releases sticky DONE.
- abort  in  1  terminates burst early.
- fifo_full  in  CHANNELS  per-channel full flags.
- we  out  CHANNELS  one-hot write enable.
- count  out  COUNT_W  writes issued in current/last burst.
- busy  out  1  high in COUNTING.
- done  out  1  one-cycle pulse on entry to DONE.
- aborted  out  1  last burst ended by abort or timeout; valid in DONE.
- timeout  out  1  last burst ended by stall timeout; valid in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; count=0; latched length/channel=0; done=0; aborted=0; timeout=0; we=0; busy=0.
- States, 2-bit encoding: IDLE=0, COUNTING=1, DONE=2; code 3 recovers to IDLE next cycle.
- IDLE:
  - start=1 with chan_sel<CHANNELS: latch length and chan_sel, count<=0, aborted<=0, timeout<=0.
  - If length!=0 go to COUNTING; if length==0 go straight to DONE (done pulse, no writes).
  - start with chan_sel>=CHANNELS is ignored.
- COUNTING:
  - we[ch] = !fifo_full[ch] & !abort (combinational); all other we bits 0.
  - Each cycle with we[ch]=1: count<=count+1.
  - When we[ch]=1 and count==length-1: go to DONE.
  - abort=1: no write that cycle; go to DONE with aborted<=1.
  - Abort takes priority over a coincident final write.
  - fifo_full[ch]=1: stay in COUNTING, count holds.
  - start is ignored.
- DONE:
  - done=1 only on the first DONE cycle (registered); count holds the final value.
  - continuous=1: return to IDLE next cycle.
  - continuous=0: stay until clear=1, then go to IDLE.
  - clear has no effect outside DONE.
- count never wraps: it stops at length, and length<=2^COUNT_W-1.
- Reset mid-burst: immediate return to reset values; any partial burst is discarded.
- Latency: start-to-first-we is 1 cycle; last write to done is 1 cycle.

Optional Feature:
- FIFO_WRITE_CTRL_STALL_TIMEOUT_EN defined:
  - Stall counter counts consecutive COUNTING cycles with fifo_full[ch]=1; it resets on any write and on entry to COUNTING.
  - At STALL_TIMEOUT: go to DONE with aborted=1, timeout=1.
- Not defined: no stall counter is instantiated, timeout is tied 0, and a full FIFO stalls indefinitely.

Decomposition:
- Shared package fifo_ctrl_pkg: state encoding constants (IDLE/COUNTING/DONE), 2-bit state type, CH_W helper function.
- One natural sub-module: stall_timer (counter plus threshold compare), instantiated only under the macro.

Test Plan:
- Reset with reset=0 mid-burst at count=5 -> all outputs 0 next edge, state IDLE.
- start, length=8, chan_sel=2, fifo_full=0 -> we=4'b0100 for exactly 8 cycles, count=8, single done pulse, busy for 8 cycles.
- length=6, chan 1; fifo_full[1]=1 for cycles 3-5 -> we low during the stall, 6 writes total, done 3 cycles later than the unstalled case.
- abort coincident with the 4th write of length=4 -> no write that cycle, count=3, aborted=1, done pulse.
- continuous=0 -> DONE holds 10 cycles until clear; continuous=1 -> IDLE one cycle after done and a new start accepted; length=0 -> done with count=0.
- Macro on, STALL_TIMEOUT=16, fifo_full held -> DONE after 16 stall cycles with timeout=1 and aborted=1.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO write controller: state encoding and channel-index width helper.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Consecutive-stall counter with threshold compare; present only when
// FIFO_WRITE_CTRL_STALL_TIMEOUT_EN is defined.
`ifdef FIFO_WRITE_CTRL_STALL_TIMEOUT_EN
module stall_timer #(
  parameter int LIMIT = 1024
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_stall,
  output logic o_hit
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)   r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (i_stall) r_cnt <= r_cnt + CW'(1);
  end

  // Fires on the LIMIT-th consecutive stalled cycle.
  assign o_hit = i_stall && (r_cnt == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/fifo_write_ctrl.sv
// Burst write controller steering a one-hot write enable to one of CHANNELS FIFOs.
// Optional stall timeout enabled by defining FIFO_WRITE_CTRL_STALL_TIMEOUT_EN.
module fifo_write_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter  int COUNT_W       = 16,
  parameter  int CHANNELS      = 4,
  parameter  int STALL_TIMEOUT = 1024,
  localparam int CH_W          = ch_w(CHANNELS)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [COUNT_W-1:0]  i_length,
  input  logic [CH_W-1:0]     i_chan_sel,
  input  logic                i_continuous,
  input  logic                i_clear,
  input  logic                i_abort,
  input  logic [CHANNELS-1:0] i_fifo_full,
  output logic [CHANNELS-1:0] o_we,
  output logic [COUNT_W-1:0]  o_count,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted,
  output logic                o_timeout
);

  if (STALL_TIMEOUT < 1) begin : g_bad_timeout
    $error("STALL_TIMEOUT must be at least 1");
  end

  state_t              r_state, w_nxt;
  logic [COUNT_W-1:0]  r_count, r_len, w_count_inc;
  logic [CH_W-1:0]     r_ch;
  logic                r_done, r_aborted, r_timeout;
  logic                w_wr, w_ch_ok, w_last, w_stall_hit;
  logic [CHANNELS-1:0] w_we;

  assign w_ch_ok     = int'(i_chan_sel) < CHANNELS;
  assign w_count_inc = r_count + COUNT_W'(1);
  assign w_last      = (w_count_inc == r_len);

`ifdef FIFO_WRITE_CTRL_STALL_TIMEOUT_EN
  stall_timer #(.LIMIT(STALL_TIMEOUT)) u_stall (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clr     ((r_state != ST_COUNTING) || w_wr),
    .i_stall   ((r_state == ST_COUNTING) && i_fifo_full[r_ch]),
    .o_hit     (w_stall_hit)
  );
`else
  assign w_stall_hit = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    w_wr  = 1'b0;
    w_we  = '0;
    case (r_state)
      ST_IDLE:
        if (i_start && w_ch_ok) w_nxt = (i_length == '0) ? ST_DONE : ST_COUNTING;
      ST_COUNTING: begin
        w_wr       = !i_fifo_full[r_ch] && !i_abort;
        w_we[r_ch] = w_wr;
        // Abort wins over a coincident final write.
        if (i_abort)               w_nxt = ST_DONE;
        else if (w_wr && w_last)   w_nxt = ST_DONE;
        else if (w_stall_hit)      w_nxt = ST_DONE;
      end
      ST_DONE:
        if (i_continuous || i_clear) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_len     <= '0;
      r_ch      <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= (w_nxt == ST_DONE) && (r_state != ST_DONE);
      if (r_state == ST_IDLE && i_start && w_ch_ok) begin
        r_len     <= i_length;
        r_ch      <= i_chan_sel;
        r_count   <= '0;
        r_aborted <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (r_state == ST_COUNTING) begin
        if (w_wr) r_count <= w_count_inc;
        if (i_abort) r_aborted <= 1'b1;
        else if (w_stall_hit) begin
          r_aborted <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_we      = w_we;
  assign o_count   = r_count;
  assign o_busy    = (r_state == ST_COUNTING);
  assign o_done    = r_done;
  assign o_aborted = r_aborted;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Randomised burst-level bench for fifo_write_ctrl with an in-bench reference model.
module tb_fifo_write_ctrl;
  localparam int CW = 16;
  localparam int CH = 4;
  localparam int TO = 16;
`ifdef FIFO_WRITE_CTRL_STALL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 0, continuous = 0, clear = 0, abort = 0;
  logic [CW-1:0] length = '0;
  logic [1:0]    chan_sel = '0;
  logic [CH-1:0] fifo_full = '0;
  logic [CH-1:0] we;
  logic [CW-1:0] count;
  logic          busy, done, aborted, timeout;

  int total = 0, passed = 0;

  fifo_write_ctrl #(.COUNT_W(CW), .CHANNELS(CH), .STALL_TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_length(length),
    .i_chan_sel(chan_sel), .i_continuous(continuous), .i_clear(clear),
    .i_abort(abort), .i_fifo_full(fifo_full), .o_we(we), .o_count(count),
    .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_cnt"}, 32'(count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ab"}, 32'(aborted), 0);
    chk({tag, "_to"}, 32'(timeout), 0);
  endtask

  // One burst: forced stalls in cycle window [sf,st], forced abort at cycle ab_at,
  // plus random full/abort with the given percent probabilities.
  task automatic run_burst(input int len, input int ch, input bit cont, input int pfull,
                           input int pabort, input int sf, input int st, input int ab_at,
                           input int hold);
    int cnt, cyc, run;
    bit ab, to, fin, abt;
    logic [CH-1:0] full, exp_we;
    @(posedge clk); #1;
    start = 1; length = CW'(len); chan_sel = 2'(ch); continuous = cont;
    abort = 0; fifo_full = '0; clear = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_we", 32'(we), 0);
    @(posedge clk); #1;
    start = 0;
    cnt = 0; cyc = 0; run = 0; ab = 0; to = 0; fin = (len == 0);
    while (!fin) begin
      full = CH'($urandom);
      full[ch] = (cyc >= sf && cyc <= st) || ($urandom_range(99) < pfull);
      abt = (cyc == ab_at) || ($urandom_range(99) < pabort);
      fifo_full = full; abort = abt;
      exp_we = (!full[ch] && !abt) ? (CH'(1) << ch) : '0;
      @(negedge clk);
      chk("cnt_busy", 32'(busy), 1);
      chk("cnt_we", 32'(we), 32'(exp_we));
      chk("cnt_count", 32'(count), cnt);
      chk("cnt_done", 32'(done), 0);
      if (abt) begin ab = 1; fin = 1; end
      else if (!full[ch]) begin
        cnt++; run = 0;
        if (cnt == len) fin = 1;
      end else begin
        run++;
        if (TO_EN && run == TO) begin ab = 1; to = 1; fin = 1; end
      end
      cyc++;
      if (!fin && cyc > 300) begin chk("burst_bound", 0, 1); fin = 1; end
      @(posedge clk); #1;
    end
    fifo_full = '0; abort = 0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_count", 32'(count), cnt);
    chk("done_ab", 32'(aborted), 32'(ab));
    chk("done_to", 32'(timeout), 32'(to));
    chk("done_busy", 32'(busy), 0);
    chk("done_we", 32'(we), 0);
    if (!cont) begin
      repeat (hold) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_done", 32'(done), 0);
        chk("hold_count", 32'(count), cnt);
        chk("hold_ab", 32'(aborted), 32'(ab));
      end
      @(posedge clk); #1; clear = 1;
    end
    @(posedge clk); #1; clear = 0;
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_count", 32'(count), cnt);
  endtask

  initial begin
    #12;
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk); #1; rst_n = 1;

    // Mid-burst reset after five writes.
    @(posedge clk); #1;
    start = 1; length = 16'd20; chan_sel = 2'd2; continuous = 1;
    @(posedge clk); #1; start = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(count), 5);
    rst_n = 0; #1;
    chk_idle_zero("async_rst");
    @(negedge clk);
    chk_idle_zero("rst_hold");
    @(posedge clk); #1; rst_n = 1;

    run_burst(8, 2, 1, 0, 0, -1, -1, -1, 0);
    run_burst(6, 1, 1, 0, 0, 2, 4, -1, 0);
    run_burst(4, 0, 1, 0, 0, -1, -1, 3, 0);
    run_burst(5, 3, 0, 0, 0, -1, -1, -1, 10);
    run_burst(0, 1, 1, 0, 0, -1, -1, -1, 0);
    run_burst(3, 2, 1, 0, 0, 1, 40, -1, 0);
    run_burst(2, 0, 0, 0, 0, 0, 30, -1, 2);

    for (int i = 0; i < 25; i++)
      run_burst($urandom_range(12), $urandom_range(3), 1'($urandom), 30, 3,
                -1, -1, -1, $urandom_range(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
